// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: widths, opcodes, FSM states.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu4_core.sv
// Purely combinational ALU: ADD/SUB/AND/OR with carry-in, carry-out and signed overflow.
// With ALU_ILLEGAL_OP_ERR_EN defined an err output flags opcodes 100-111.
module alu4_core #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic [OP_W-1:0]   op,
`ifdef ALU_ILLEGAL_OP_ERR_EN
  output logic              err,
`endif
  output logic [DATA_W-1:0] result,
  output logic              cout,
  output logic              ovf
);
  import alu_pkg::*;

  logic [DATA_W:0] sum;

  // SUB is a + ~b + cin, so cout=1 means no borrow when cin=1
  always_comb begin
    sum    = '0;
    result = '0;
    cout   = 1'b0;
    ovf    = 1'b0;
`ifdef ALU_ILLEGAL_OP_ERR_EN
    err    = 1'b0;
`endif
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
        result = sum[DATA_W-1:0];
        cout   = sum[DATA_W];
        ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, cin};
        result = sum[DATA_W-1:0];
        cout   = sum[DATA_W];
        ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      default: begin
`ifdef ALU_ILLEGAL_OP_ERR_EN
        err = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Round-robin arbiter + IDLE/EXEC/RESP FSM sharing one alu4_core between two requesters.
// Optional macro ALU_ILLEGAL_OP_ERR_EN adds the registered rsp_err output.
module alu_arbiter_ctrl #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [1:0]          req_cin,
  input  logic [2*OP_W-1:0]   req_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_result,
  output logic                rsp_cout,
  output logic                rsp_ovf,
`ifdef ALU_ILLEGAL_OP_ERR_EN
  output logic                rsp_err,
`endif
  output logic                busy
);
  import alu_pkg::*;

  state_t              state;
  state_t              state_nxt;
  logic                rr_ptr;
  logic                grant_id;
  logic                grant_en;
  logic [DATA_W-1:0]   lat_a;
  logic [DATA_W-1:0]   lat_b;
  logic                lat_cin;
  logic [OP_W-1:0]     lat_op;
  logic                lat_id;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_cout;
  logic                alu_ovf;
`ifdef ALU_ILLEGAL_OP_ERR_EN
  logic                alu_err;
`endif

  // rr_ptr holds the last winner; on a tie the other requester is granted
  always_comb begin
    grant_id  = req_valid[1];
    grant_en  = 1'b0;
    req_ready = 2'b00;
    state_nxt = state;
    if (req_valid == 2'b11) begin
      grant_id = ~rr_ptr;
    end
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_en            = 1'b1;
          req_ready[grant_id] = 1'b1;
          state_nxt           = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= 1'b1;
      lat_a   <= '0;
      lat_b   <= '0;
      lat_cin <= 1'b0;
      lat_op  <= '0;
      lat_id  <= 1'b0;
    end else if (grant_en) begin
      rr_ptr  <= grant_id;
      lat_id  <= grant_id;
      lat_a   <= grant_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
      lat_b   <= grant_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
      lat_cin <= grant_id ? req_cin[1] : req_cin[0];
      lat_op  <= grant_id ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
    end
  end

  alu4_core #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .a      (lat_a),
    .b      (lat_b),
    .cin    (lat_cin),
    .op     (lat_op),
`ifdef ALU_ILLEGAL_OP_ERR_EN
    .err    (alu_err),
`endif
    .result (alu_result),
    .cout   (alu_cout),
    .ovf    (alu_ovf)
  );

  // Response fields are captured once in EXEC and then held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
`ifdef ALU_ILLEGAL_OP_ERR_EN
      rsp_err    <= 1'b0;
`endif
    end else if (state == EXEC) begin
      rsp_id     <= lat_id;
      rsp_result <= alu_result;
      rsp_cout   <= alu_cout;
      rsp_ovf    <= alu_ovf;
`ifdef ALU_ILLEGAL_OP_ERR_EN
      rsp_err    <= alu_err;
`endif
    end
  end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Scoreboard bench for alu_arbiter_ctrl: directed cases plus randomized traffic against an arithmetic model.
module tb_alu_arbiter_ctrl;
  import alu_pkg::*;

  localparam int DW = 4;
  localparam int OW = 3;

  typedef struct {
    logic [DW-1:0] result;
    logic          cout;
    logic          ovf;
    logic          err;
    logic          id;
    int            acc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*DW-1:0] req_a;
  logic [2*DW-1:0] req_b;
  logic [1:0]    req_cin;
  logic [2*OW-1:0] req_op;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [DW-1:0] rsp_result;
  logic          rsp_cout;
  logic          rsp_ovf;
  logic          busy;
`ifdef ALU_ILLEGAL_OP_ERR_EN
  logic          rsp_err;
`endif

  exp_t     sb[$];
  int       tests;
  int       fails;
  int       cyc;
  int       pushed;
  int       retired;
  int       dropped;
  bit       rr_model;
  bit [1:0] accepted;
  bit       rand_on;

  alu_arbiter_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf),
`ifdef ALU_ILLEGAL_OP_ERR_EN
    .rsp_err    (rsp_err),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU in plain integer arithmetic: unsigned sum for carry, signed sum for overflow
  function automatic exp_t model(logic [DW-1:0] a, logic [DW-1:0] b, logic cin, logic [OW-1:0] op, logic id);
    exp_t e;
    int ua, ub, sa, sbv, s, ss;
    ua  = int'(a);
    ub  = int'(b);
    sa  = (ua >= 8) ? ua - 16 : ua;
    sbv = (ub >= 8) ? ub - 16 : ub;
    e.result = '0;
    e.cout   = 1'b0;
    e.ovf    = 1'b0;
    e.err    = 1'b0;
    e.id     = id;
    e.acc    = 0;
    case (int'(op))
      0: begin
        s  = ua + ub + int'(cin);
        ss = sa + sbv + int'(cin);
        e.result = 4'(s % 16);
        e.cout   = (s > 15);
        e.ovf    = (ss > 7) || (ss < -8);
      end
      1: begin
        s  = ua + (15 - ub) + int'(cin);
        ss = sa - sbv - 1 + int'(cin);
        e.result = 4'(s % 16);
        e.cout   = (s > 15);
        e.ovf    = (ss > 7) || (ss < -8);
      end
      2: e.result = a & b;
      3: e.result = a | b;
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkResetOutputs(string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    checkOutput({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    checkOutput({tag, "_rsp_cout"}, 32'(rsp_cout), 32'd0);
    checkOutput({tag, "_rsp_ovf"}, 32'(rsp_ovf), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef ALU_ILLEGAL_OP_ERR_EN
    checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
`endif
  endtask

  // Called on a falling edge; holds valid and payload until the arbiter takes it
  task automatic applyStimulus(int i, logic [DW-1:0] a, logic [DW-1:0] b, logic cin, logic [OW-1:0] op);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_cin[i]        = cin;
    req_op[i*OW +: OW] = op;
    req_valid[i]      = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (accepted[i]) begin
        req_valid[i] = 1'b0;
        return;
      end
    end
    req_valid[i] = 1'b0;
    checkOutput($sformatf("accept_timeout_req%0d", i), 32'd0, 32'd1);
  endtask

  task automatic randomOp(int i);
    logic [OW-1:0] op;
    op = (($urandom_range(0, 7)) == 0) ? OW'($urandom_range(4, 7)) : OW'($urandom_range(0, 3));
    applyStimulus(i, DW'($urandom), DW'($urandom), 1'($urandom), op);
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 60; k++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Called on a falling edge; asserts reset mid-cycle and expects outputs to clear immediately
  task automatic resetDuring(string tag);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetOutputs(tag);
    dropped += sb.size();
    sb.delete();
    rr_model = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Arbitration model: one op in flight at a time, ties go to the requester that did not win last
  always @(negedge clk) begin
    bit [1:0] exp_ready;
    bit       g;
    int       gi;
    exp_t     e;
    #1;
    accepted = 2'b00;
    if (rst_n) begin
      cyc++;
      exp_ready = 2'b00;
      g = 1'b0;
      if (sb.size() == 0 && req_valid != 2'b00) begin
        g = (req_valid == 2'b11) ? ~rr_model : req_valid[1];
        exp_ready[g] = 1'b1;
      end
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("busy", 32'(busy), 32'(sb.size() != 0));
      if (exp_ready != 2'b00) begin
        gi = int'(g);
        e = model(req_a[gi*DW +: DW], req_b[gi*DW +: DW], req_cin[gi], req_op[gi*OW +: OW], g);
        e.acc = cyc;
        sb.push_back(e);
        pushed++;
        rr_model = g;
        accepted[g] = 1'b1;
      end
    end
  end

  // Response monitor: valid exactly two cycles after accept, fields held until consumed
  always @(negedge clk) begin
    bit exp_valid;
    #2;
    if (rst_n) begin
      exp_valid = (sb.size() > 0) && (cyc >= sb[0].acc + 2);
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      if (exp_valid && rsp_valid) begin
        checkOutput("rsp_id", 32'(rsp_id), 32'(sb[0].id));
        checkOutput("rsp_result", 32'(rsp_result), 32'(sb[0].result));
        checkOutput("rsp_cout", 32'(rsp_cout), 32'(sb[0].cout));
        checkOutput("rsp_ovf", 32'(rsp_ovf), 32'(sb[0].ovf));
`ifdef ALU_ILLEGAL_OP_ERR_EN
        checkOutput("rsp_err", 32'(rsp_err), 32'(sb[0].err));
`endif
        if (rsp_ready) begin
          void'(sb.pop_front());
          retired++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_on) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    tests = 0; fails = 0; cyc = 0;
    pushed = 0; retired = 0; dropped = 0;
    rr_model = 1'b1; accepted = 2'b00; rand_on = 1'b0;
    rst_n = 1'b0; req_valid = 2'b00; req_a = '0; req_b = '0;
    req_cin = 2'b00; req_op = '0; rsp_ready = 1'b1;
    #1;
    checkResetOutputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, 4'd7, 4'd1, 1'b0, OP_ADD);
    applyStimulus(1, 4'd3, 4'd5, 1'b1, OP_SUB);
    applyStimulus(0, 4'd6, 4'd3, 1'b0, OP_AND);
    applyStimulus(1, 4'd9, 4'd4, 1'b0, OP_OR);
    applyStimulus(0, 4'd8, 4'd8, 1'b1, OP_ADD);
    applyStimulus(1, 4'd0, 4'd1, 1'b1, OP_SUB);
    waitIdle();

    fork
      repeat (6) randomOp(0);
      repeat (6) randomOp(1);
    join
    waitIdle();

    rsp_ready = 1'b0;
    applyStimulus(0, 4'd5, 4'd6, 1'b1, OP_ADD);
    fork
      applyStimulus(1, 4'd12, 4'd10, 1'b0, OP_AND);
      begin
        repeat (7) @(negedge clk);
        rsp_ready = 1'b1;
      end
    join
    waitIdle();

    applyStimulus(0, 4'd15, 4'd15, 1'b0, OP_OR);
    resetDuring("rst_exec");
    fork
      applyStimulus(0, 4'd2, 4'd2, 1'b0, OP_ADD);
      applyStimulus(1, 4'd2, 4'd3, 1'b0, OP_OR);
    join
    waitIdle();

    rsp_ready = 1'b0;
    applyStimulus(1, 4'd13, 4'd11, 1'b0, OP_AND);
    @(negedge clk);
    resetDuring("rst_resp");
    rsp_ready = 1'b1;
    fork
      applyStimulus(0, 4'd1, 4'd14, 1'b1, OP_SUB);
      applyStimulus(1, 4'd7, 4'd7, 1'b1, OP_ADD);
    join
    waitIdle();

    applyStimulus(0, 4'd4, 4'd2, 1'b1, 3'b101);
    applyStimulus(1, 4'd15, 4'd15, 1'b1, 3'b111);
    waitIdle();

    rand_on = 1'b1;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: randomOp(0);
        1: randomOp(1);
        default: fork
          randomOp(0);
          randomOp(1);
        join
      endcase
    end
    rand_on = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    checkOutput("responses_accounted", 32'(pushed), 32'(retired + dropped));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
